// File: rtl/day1_input_sequencer_if.sv
// Byte-stream in / token-out bundle for day1_input_sequencer.
// DAY1_SEQ_STATS_EN adds the value_count / group_count statistics outputs.
interface day1_input_sequencer_if #(
  parameter int VAL_W = 16,
  parameter int CNT_W = 8
);
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [VAL_W-1:0] out_val;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             err_ovf;
  logic             err_char;
  logic             err_zero;
`ifdef DAY1_SEQ_STATS_EN
  logic [15:0]      value_count;
  logic [CNT_W-1:0] group_count;
`endif

  modport master (
    output in_byte, in_valid, in_last, out_ready,
    input  in_ready, out_val, out_valid, done, err_ovf, err_char, err_zero
`ifdef DAY1_SEQ_STATS_EN
    , input value_count, group_count
`endif
  );

  modport slave (
    input  in_byte, in_valid, in_last, out_ready,
    output in_ready, out_val, out_valid, done, err_ovf, err_char, err_zero
`ifdef DAY1_SEQ_STATS_EN
    , output value_count, group_count
`endif
  );
endinterface

// File: rtl/day1_input_sequencer.sv
// Parses Day-1 ASCII text into value / 0-separator tokens for the calorie accumulator.
// Optional DAY1_SEQ_STATS_EN adds transferred-token counters.
module day1_input_sequencer #(
  parameter int VAL_W = 16,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  day1_input_sequencer_if.slave bus
);
  typedef enum logic [2:0] {LINE_START, DIGITS, EMIT, EMIT_SEP, DONE} state_t;

  localparam logic [VAL_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [VAL_W-1:0] out_val_q, out_val_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             last_was_sep_q, last_was_sep_d;
  logic             flush_q, flush_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_char_q, err_char_d;
  logic             err_zero_q, err_zero_d;

  logic             in_ready;
  logic             accept;
  logic             xfer;
  logic             is_digit, is_nl, is_cr;
  logic [VAL_W+3:0] acc_wide;
  logic             line_pend, emit, sep_seen;
  logic [VAL_W-1:0] acc_n, emit_val;

  assign in_ready = rst_n && (state_q == LINE_START || state_q == DIGITS) && !out_valid_q && !done_q;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_q && bus.out_ready;
  assign is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
  assign is_nl    = (bus.in_byte == 8'h0A);
  assign is_cr    = (bus.in_byte == 8'h0D);
  // acc*10 + digit, wide enough that saturation can be detected
  assign acc_wide = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0}
                  + {{VAL_W{1'b0}}, bus.in_byte[3:0]};

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    out_val_d      = out_val_q;
    out_valid_d    = out_valid_q;
    done_d         = done_q;
    last_was_sep_d = last_was_sep_q;
    flush_d        = flush_q;
    err_ovf_d      = err_ovf_q;
    err_char_d     = err_char_q;
    err_zero_d     = err_zero_q;
    line_pend      = (state_q == DIGITS);
    acc_n          = acc_q;
    sep_seen       = last_was_sep_q;
    emit           = 1'b0;
    emit_val       = '0;
    case (state_q)
      LINE_START, DIGITS: begin
        if (accept) begin
          if (is_digit) begin
            line_pend = 1'b1;
            if (acc_wide > {4'b0000, ACC_MAX}) begin
              acc_n     = ACC_MAX;
              err_ovf_d = 1'b1;
            end else begin
              acc_n = acc_wide[VAL_W-1:0];
            end
          end else if (!is_nl && !is_cr) begin
            err_char_d = 1'b1;
          end
          // A digit line closes on '\n' or at end of file; a zero value is dropped.
          if ((is_nl || bus.in_last) && line_pend) begin
            if (acc_n != '0) begin
              emit     = 1'b1;
              emit_val = acc_n;
              sep_seen = 1'b0;
            end else begin
              err_zero_d = 1'b1;
            end
            acc_n     = '0;
            line_pend = 1'b0;
          end else if (is_nl && !sep_seen) begin
            emit     = 1'b1;
            sep_seen = 1'b1;
          end
          if (bus.in_last && !emit && !sep_seen) begin
            emit     = 1'b1;
            sep_seen = 1'b1;
          end
          acc_d          = acc_n;
          last_was_sep_d = sep_seen;
          out_val_d      = emit_val;
          out_valid_d    = emit;
          if (!bus.in_last) begin
            state_d = emit ? EMIT : (line_pend ? DIGITS : LINE_START);
          end else if (emit && emit_val != '0) begin
            state_d = EMIT;
            flush_d = 1'b1;
          end else if (emit) begin
            state_d = EMIT_SEP;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (xfer) begin
          if (flush_q) begin
            // final value taken: the closing separator follows back-to-back
            out_val_d      = '0;
            last_was_sep_d = 1'b1;
            state_d        = EMIT_SEP;
          end else begin
            out_valid_d = 1'b0;
            state_d     = LINE_START;
          end
        end
      end
      EMIT_SEP: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
          done_d      = 1'b1;
        end
      end
      DONE: ;
      default: state_d = LINE_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LINE_START;
      acc_q          <= '0;
      out_val_q      <= '0;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      last_was_sep_q <= 1'b1;
      flush_q        <= 1'b0;
      err_ovf_q      <= 1'b0;
      err_char_q     <= 1'b0;
      err_zero_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      out_val_q      <= out_val_d;
      out_valid_q    <= out_valid_d;
      done_q         <= done_d;
      last_was_sep_q <= last_was_sep_d;
      flush_q        <= flush_d;
      err_ovf_q      <= err_ovf_d;
      err_char_q     <= err_char_d;
      err_zero_q     <= err_zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_val   = out_val_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_char  = err_char_q;
  assign bus.err_zero  = err_zero_q;

`ifdef DAY1_SEQ_STATS_EN
  logic [15:0]      value_count_q, value_count_d;
  logic [CNT_W-1:0] group_count_q, group_count_d;

  always_comb begin
    value_count_d = value_count_q;
    group_count_d = group_count_q;
    if (xfer) begin
      if (out_val_q != '0) value_count_d = value_count_q + 16'd1;
      else                 group_count_d = group_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_count_q <= '0;
      group_count_q <= '0;
    end else begin
      value_count_q <= value_count_d;
      group_count_q <= group_count_d;
    end
  end

  assign bus.value_count = value_count_q;
  assign bus.group_count = group_count_q;
`endif
endmodule

// File: tb/tb_day1_input_sequencer.sv
// Bench for day1_input_sequencer: directed files from the test plan plus random files,
// checked against a line-based reference parse of the same byte stream.
module tb_day1_input_sequencer;
  localparam int          VAL_W = 16;
  localparam int          CNT_W = 8;
  localparam int unsigned MAXV  = 65535;

  logic clk;
  logic rst_n;
  logic bp_rand;

  day1_input_sequencer_if #(.VAL_W(VAL_W), .CNT_W(CNT_W)) ifc ();

  day1_input_sequencer #(.VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  file_q[$];
  int unsigned exp_q[$];
  logic [15:0] got_q[$];
  bit          e_ovf, e_char, e_zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && ifc.out_valid && ifc.out_ready) got_q.push_back(ifc.out_val);

  always @(negedge clk)
    if (bp_rand) ifc.out_ready = 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: parse the file line by line, then close the last group.
  task automatic model();
    int unsigned v    = 0;
    bit          has_d = 0;
    bit          lsep  = 1;
    exp_q.delete();
    e_ovf = 0; e_char = 0; e_zero = 0;
    foreach (file_q[i]) begin
      logic [7:0] c;
      c = file_q[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        has_d = 1;
        v = v * 10 + int'(c - 8'h30);
        if (v > MAXV) begin v = MAXV; e_ovf = 1; end
      end else if (c == 8'h0A) begin
        if (has_d) begin
          if (v == 0) e_zero = 1;
          else begin exp_q.push_back(v); lsep = 0; end
        end else if (!lsep) begin
          exp_q.push_back(0); lsep = 1;
        end
        v = 0; has_d = 0;
      end else if (c != 8'h0D) begin
        e_char = 1;
      end
    end
    if (has_d) begin
      if (v == 0) e_zero = 1;
      else begin exp_q.push_back(v); lsep = 0; end
    end
    if (!lsep) exp_q.push_back(0);
  endtask

  task automatic load_str(input string s);
    file_q.delete();
    for (int i = 0; i < s.len(); i++) file_q.push_back(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      check("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
    end else begin
      ifc.in_byte  = b;
      ifc.in_valid = 1'b1;
      ifc.in_last  = last;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      ifc.in_last  = 1'b0;
    end
  endtask

  task automatic finish_check(input string tag);
    int n = 0;
    int nv = 0;
    while (!ifc.done && n < 2000) begin @(negedge clk); n++; end
    check({tag, ".done"}, 32'(ifc.done), 32'd1);
    check({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s.tok%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
      if (exp_q[i] != 0) nv++;
    end
    check({tag, ".err_ovf"},  32'(ifc.err_ovf),  32'(e_ovf));
    check({tag, ".err_char"}, 32'(ifc.err_char), 32'(e_char));
    check({tag, ".err_zero"}, 32'(ifc.err_zero), 32'(e_zero));
    check({tag, ".in_ready_done"}, 32'(ifc.in_ready), 32'd0);
    check({tag, ".out_valid_done"}, 32'(ifc.out_valid), 32'd0);
`ifdef DAY1_SEQ_STATS_EN
    check({tag, ".value_count"}, 32'(ifc.value_count), 32'(nv));
    check({tag, ".group_count"}, 32'(ifc.group_count), 32'(exp_q.size() - nv));
`endif
    $display("file %s: %0d bytes, %0d tokens expected, %0d received", tag, file_q.size(), exp_q.size(), got_q.size());
  endtask

  task automatic run_file(input string tag);
    got_q.delete();
    model();
    for (int i = 0; i < file_q.size(); i++) send_byte(file_q[i], i == file_q.size() - 1);
    finish_check(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic gen_random();
    int nl = $urandom_range(1, 8);
    file_q.delete();
    for (int l = 0; l < nl; l++) begin
      int    kind = $urandom_range(0, 9);
      string s;
      if (kind <= 1)      s = "";
      else if (kind == 2) s = $sformatf("%0dx%0d", $urandom_range(0, 99), $urandom_range(0, 999));
      else if (kind == 3) s = "00";
      else                s = $sformatf("%0d", $urandom_range(0, 99999));
      if ($urandom_range(0, 4) == 0) s = {s, "\r"};
      if (l != nl - 1 || $urandom_range(0, 1) == 1) s = {s, "\n"};
      for (int i = 0; i < s.len(); i++) file_q.push_back(s[i]);
    end
    if (file_q.size() == 0) file_q.push_back(8'h0A);
  endtask

  initial begin
    rst_n         = 1'b0;
    bp_rand       = 1'b0;
    ifc.in_byte   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.in_ready",  32'(ifc.in_ready),  32'd0);
    check("rst.out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst.out_val",   32'(ifc.out_val),   32'd0);
    check("rst.done",      32'(ifc.done),      32'd0);
    check("rst.errs", {29'd0, ifc.err_ovf, ifc.err_char, ifc.err_zero}, 32'd0);
`ifdef DAY1_SEQ_STATS_EN
    check("rst.value_count", 32'(ifc.value_count), 32'd0);
    check("rst.group_count", 32'(ifc.group_count), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.in_ready", 32'(ifc.in_ready), 32'd1);

    load_str("1000\n2000\n\n3000\n"); run_file("groups");
    do_reset(); load_str("5\n\n\n\n7");   run_file("blank_run");
    do_reset(); load_str("70000\n12\n");  run_file("overflow");
    do_reset(); load_str("4a2\n0\n");     run_file("char_zero");

    // Backpressure: token 9 must hold for five stalled cycles.
    do_reset();
    ifc.out_ready = 1'b0;
    load_str("9\n\r"); model(); got_q.delete();
    send_byte(8'h39, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp.out_valid%0d", k), 32'(ifc.out_valid), 32'd1);
      check($sformatf("bp.out_val%0d", k),   32'(ifc.out_val),   32'd9);
      check($sformatf("bp.in_ready%0d", k),  32'(ifc.in_ready),  32'd0);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("bp.out_valid_drop", 32'(ifc.out_valid), 32'd0);
    check("bp.in_ready_back",  32'(ifc.in_ready),  32'd1);
    send_byte(8'h0D, 1'b1);
    finish_check("backpressure");

    // Asynchronous reset while token 123 is pending.
    do_reset();
    ifc.out_ready = 1'b0;
    load_str("123\n");
    foreach (file_q[i]) send_byte(file_q[i], 1'b0);
    check("arst.pending_valid", 32'(ifc.out_valid), 32'd1);
    check("arst.pending_val",   32'(ifc.out_val),   32'd123);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(ifc.out_valid), 32'd0);
    check("arst.in_ready",  32'(ifc.in_ready),  32'd0);
`ifdef DAY1_SEQ_STATS_EN
    check("arst.value_count", 32'(ifc.value_count), 32'd0);
    check("arst.group_count", 32'(ifc.group_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    ifc.out_ready = 1'b1;
    load_str("8\n"); run_file("after_rst");

    bp_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      do_reset();
      gen_random();
      run_file($sformatf("rand%0d", t));
    end
    bp_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
